// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode and
// funct constants, ALU operation codes, datapath mux selects and instruction class.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_MUL_WAIT = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_WB_ALU   = 4'd9,
      S_WB_MEM   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_MUL = 6'b011100;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [4:0] RT_BLTZ = 5'd0;
   localparam logic [4:0] RT_BGEZ = 5'd1;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SLT = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_SRL = 4'd8;
   localparam logic [3:0] ALU_MUL = 4'd9;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   localparam logic [1:0] M2R_MEM = 2'd0;
   localparam logic [1:0] M2R_ALU = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;

   localparam logic [1:0] SRCB_RT   = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_BOFF = 2'd3;

   localparam logic [1:0] SZ_WORD = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   typedef enum logic [2:0] {
      CL_ILLEGAL, CL_RTYPE, CL_MUL, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP
   } cls_t;

   typedef enum logic [2:0] {
      BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BGEZ, BR_BLTZ, BR_BAD
   } br_t;

   typedef enum logic [1:0] {JMP_J, JMP_JAL, JMP_JR} jmp_t;

   typedef struct packed {
      cls_t       cls;
      logic [1:0] size;
      br_t        br;
      jmp_t       jmp;
   } instr_t;

   // Unrecognised R-type functs are treated as undecodable, same as unknown opcodes.
   function automatic instr_t classify(logic [5:0] op, logic [5:0] fn, logic [4:0] rt);
      instr_t d;
      d     = '0;
      d.cls = CL_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
               FN_NOR, FN_SLT, FN_SLL, FN_SRL: d.cls = CL_RTYPE;
               FN_MUL: d.cls = CL_MUL;
               FN_JR: begin
                  d.cls = CL_JUMP;
                  d.jmp = JMP_JR;
               end
               default: d.cls = CL_ILLEGAL;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: d.cls = CL_IALU;
         OP_LW: begin d.cls = CL_LOAD;  d.size = SZ_WORD; end
         OP_LH: begin d.cls = CL_LOAD;  d.size = SZ_HALF; end
         OP_LB: begin d.cls = CL_LOAD;  d.size = SZ_BYTE; end
         OP_SW: begin d.cls = CL_STORE; d.size = SZ_WORD; end
         OP_SH: begin d.cls = CL_STORE; d.size = SZ_HALF; end
         OP_SB: begin d.cls = CL_STORE; d.size = SZ_BYTE; end
         OP_BEQ:  begin d.cls = CL_BRANCH; d.br = BR_BEQ;  end
         OP_BNE:  begin d.cls = CL_BRANCH; d.br = BR_BNE;  end
         OP_BLEZ: begin d.cls = CL_BRANCH; d.br = BR_BLEZ; end
         OP_BGTZ: begin d.cls = CL_BRANCH; d.br = BR_BGTZ; end
         OP_REGIMM: begin
            d.cls = CL_BRANCH;
            d.br  = (rt == RT_BLTZ) ? BR_BLTZ :
                    (rt == RT_BGEZ) ? BR_BGEZ : BR_BAD;
         end
         OP_J:   begin d.cls = CL_JUMP; d.jmp = JMP_J;   end
         OP_JAL: begin d.cls = CL_JUMP; d.jmp = JMP_JAL; end
         default: d.cls = CL_ILLEGAL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// Combinational ALU operation select from opcode and funct; non-ALU opcodes
// fall back to ADD, which is what address and PC arithmetic need.
module ctrl_alu_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] op_code,
   input  logic [5:0] funct,
   output logic [3:0] alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      if (op_code == OP_RTYPE) begin
         case (funct)
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_XOR: alu_op = ALU_XOR;
            FN_NOR: alu_op = ALU_NOR;
            FN_SLT: alu_op = ALU_SLT;
            FN_SLL: alu_op = ALU_SLL;
            FN_SRL: alu_op = ALU_SRL;
            FN_MUL: alu_op = ALU_MUL;
            default: alu_op = ALU_ADD;
         endcase
      end else begin
         case (op_code)
            OP_ANDI: alu_op = ALU_AND;
            OP_ORI:  alu_op = ALU_OR;
            OP_XORI: alu_op = ALU_XOR;
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for a shared-memory datapath, with stallable memory and a fixed-latency multiplier.
//
// state      | meaning
// IDLE       | after reset, all controls low
// FETCH      | read instruction at PC, PC += 4 when memory is ready
// DECODE     | latch instruction class, precompute branch target
// EXEC_R     | register-register ALU op
// EXEC_I     | register-immediate ALU op
// MUL_WAIT   | hold multiplier operands until the result is valid
// MEM_ADDR   | effective address rs + imm
// MEM_RD     | data read, held until memory ready
// MEM_WR     | data write, held until memory ready
// WB_ALU     | write ALUOut to rd/rt
// WB_MEM     | write load data to rt
// BRANCH     | compare and conditionally load PC with branch target
// JUMP       | load PC with jump target or rs; JAL links into $31
module mips_multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int MUL_LATENCY = 3,
   parameter int ALUOP_W     = 4,
   parameter int STATE_W     = 4
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [5:0]         OPCode,
   input  logic [5:0]         Function,
   input  logic [4:0]         Rt,
   input  logic               Zero,
   input  logic               Neg,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemToReg,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         PCSrc,
   output logic [1:0]         LoadType,
   output logic [1:0]         StoreType,
   output logic               IllegalOp,
   output logic [STATE_W-1:0] State
);

   state_t     state;
   instr_t     instr;
   instr_t     dec;
   logic [3:0] mul_cnt;
   logic [3:0] alu_dec_op;
   logic [3:0] alu_op;
   logic       br_taken;

   assign dec = classify(OPCode, Function, Rt);

   ctrl_alu_decode u_alu_decode (
      .op_code (OPCode),
      .funct   (Function),
      .alu_op  (alu_dec_op)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= S_IDLE;
         instr   <= '0;
         mul_cnt <= '0;
      end else begin
         case (state)
            S_IDLE:  state <= S_FETCH;
            S_FETCH: if (MemReady) state <= S_DECODE;
            S_DECODE: begin
               instr <= dec;
               case (dec.cls)
                  CL_RTYPE, CL_MUL:  state <= S_EXEC_R;
                  CL_IALU:           state <= S_EXEC_I;
                  CL_LOAD, CL_STORE: state <= S_MEM_ADDR;
                  CL_BRANCH:         state <= S_BRANCH;
                  CL_JUMP:           state <= S_JUMP;
                  default:           state <= S_FETCH;
               endcase
            end
            S_EXEC_R: begin
               if (instr.cls == CL_MUL) begin
                  state   <= S_MUL_WAIT;
                  mul_cnt <= 4'(MUL_LATENCY - 1);
               end else begin
                  state <= S_WB_ALU;
               end
            end
            S_EXEC_I: state <= S_WB_ALU;
            S_MUL_WAIT: begin
               if (mul_cnt == 4'd0) state <= S_WB_ALU;
               else                 mul_cnt <= mul_cnt - 4'd1;
            end
            S_MEM_ADDR: state <= (instr.cls == CL_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (MemReady) state <= S_WB_MEM;
            S_MEM_WR:   if (MemReady) state <= S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Zero/Neg come from the SUB of rs and rt (or rs alone for compare-with-zero forms).
   always_comb begin
      br_taken = 1'b0;
      case (instr.br)
         BR_BEQ:  br_taken = Zero;
         BR_BNE:  br_taken = !Zero;
         BR_BLEZ: br_taken = Neg | Zero;
         BR_BGTZ: br_taken = !Neg & !Zero;
         BR_BGEZ: br_taken = !Neg;
         BR_BLTZ: br_taken = Neg;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      RegDst    = REGDST_RT;
      MemToReg  = M2R_MEM;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_RT;
      alu_op    = ALU_ADD;
      PCSrc     = PCSRC_ALU;
      LoadType  = SZ_WORD;
      StoreType = SZ_WORD;
      IllegalOp = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            PCWrite = MemReady;
            IRWrite = MemReady;
         end
         S_DECODE: begin
            ALUSrcB   = SRCB_BOFF;
            IllegalOp = (dec.cls == CL_ILLEGAL);
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            alu_op  = alu_dec_op;
         end
         S_MUL_WAIT: begin
            ALUSrcA = 1'b1;
            alu_op  = ALU_MUL;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            alu_op  = alu_dec_op;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_RD: begin
            MemRead  = 1'b1;
            IorD     = 1'b1;
            LoadType = instr.size;
         end
         S_MEM_WR: begin
            MemWrite  = 1'b1;
            IorD      = 1'b1;
            StoreType = instr.size;
         end
         S_WB_ALU: begin
            RegWrite = 1'b1;
            MemToReg = M2R_ALU;
            RegDst   = (instr.cls == CL_RTYPE || instr.cls == CL_MUL) ? REGDST_RD : REGDST_RT;
         end
         S_WB_MEM: RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA   = 1'b1;
            alu_op    = ALU_SUB;
            PCSrc     = PCSRC_ALUOUT;
            PCWrite   = br_taken;
            IllegalOp = (instr.br == BR_BAD);
         end
         S_JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = (instr.jmp == JMP_JR) ? PCSRC_RS : PCSRC_JUMP;
            if (instr.jmp == JMP_JAL) begin
               RegWrite = 1'b1;
               RegDst   = REGDST_RA;
               MemToReg = M2R_PC4;
            end
         end
         default: ;
      endcase
   end

   assign ALUOp = ALUOP_W'(alu_op);
   assign State = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench: per-instruction cycle sequences and per-phase control
// values derived from the instruction set behaviour, compared every cycle.
module tb_mips_multicycle_controller;
   import ctrl_pkg::*;

   localparam int MUL_LAT = 3;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [5:0] OPCode = '0, Function = '0;
   logic [4:0] Rt = '0;
   logic       Zero = 1'b0, Neg = 1'b0, MemReady = 1'b1;
   logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, IllegalOp;
   logic [1:0] RegDst, MemToReg, ALUSrcB, PCSrc, LoadType, StoreType;
   logic [3:0] ALUOp, State;

   always #5 Clk = ~Clk;

   mips_multicycle_controller #(.MUL_LATENCY(MUL_LAT), .ALUOP_W(4), .STATE_W(4)) dut (
      .Clk(Clk), .Rst(Rst), .OPCode(OPCode), .Function(Function), .Rt(Rt),
      .Zero(Zero), .Neg(Neg), .MemReady(MemReady),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
      .LoadType(LoadType), .StoreType(StoreType), .IllegalOp(IllegalOp), .State(State)
   );

   typedef struct packed {
      logic       pcw, irw, iord, mr, mw, rw;
      logic [1:0] rd, m2r;
      logic       sa;
      logic [1:0] sb;
      logic [3:0] aop;
      logic [1:0] pcs, ldt, stt;
      logic       ill;
      logic [3:0] sid;
   } out_t;

   out_t act;
   assign act = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
                 ALUSrcA, ALUSrcB, ALUOp, PCSrc, LoadType, StoreType, IllegalOp, State};

   localparam int K_ALU_R = 0, K_MUL = 1, K_ALU_I = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5,
                  K_BRBAD = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rt;
      int         kind;
      int         aop;
      int         arg;
   } ins_t;

   ins_t   tbl[$];
   string  nm[$];
   state_t seq[$];

   int n_err = 0, n_chk = 0;
   int c_cycles, c_mulwait, c_rw, c_mrd, c_ill;
   out_t cap_jump, cap_br, cap_wbmem, cap_wbalu;

   task automatic chk(string name, logic [31:0] a, logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
      end
   endtask

   function automatic void add(logic [5:0] op, logic [5:0] fn, logic [4:0] rt,
                               int kind, int aop, int arg, string name);
      ins_t t;
      t.op = op; t.fn = fn; t.rt = rt; t.kind = kind; t.aop = aop; t.arg = arg;
      tbl.push_back(t);
      nm.push_back(name);
   endfunction

   function automatic int find(string name);
      foreach (nm[i]) if (nm[i] == name) return i;
      return 0;
   endfunction

   // Branch conditions as signed comparisons of the ALU result against zero.
   function automatic bit taken(ins_t in, int a);
      if (in.kind != K_BR) return 1'b0;
      case (in.arg)
         0: return a == 0;
         1: return a != 0;
         2: return a <= 0;
         3: return a > 0;
         4: return a >= 0;
         default: return a < 0;
      endcase
   endfunction

   function automatic void build(ins_t in);
      seq.delete();
      seq.push_back(S_FETCH);
      seq.push_back(S_DECODE);
      case (in.kind)
         K_ALU_R: begin seq.push_back(S_EXEC_R); seq.push_back(S_WB_ALU); end
         K_MUL: begin
            seq.push_back(S_EXEC_R);
            for (int i = 0; i < MUL_LAT; i++) seq.push_back(S_MUL_WAIT);
            seq.push_back(S_WB_ALU);
         end
         K_ALU_I: begin seq.push_back(S_EXEC_I); seq.push_back(S_WB_ALU); end
         K_LOAD: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_RD); seq.push_back(S_WB_MEM); end
         K_STORE: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_WR); end
         K_BR, K_BRBAD: seq.push_back(S_BRANCH);
         K_J, K_JAL, K_JR: seq.push_back(S_JUMP);
         default: ;
      endcase
   endfunction

   function automatic out_t model(state_t ph, ins_t in, bit rdy, int a);
      out_t e;
      e = '0;
      e.sid = 4'(ph);
      case (ph)
         S_FETCH: begin e.mr = 1; e.sb = 2'd1; e.pcw = rdy; e.irw = rdy; end
         S_DECODE: begin e.sb = 2'd3; e.ill = (in.kind == K_ILL); end
         S_EXEC_R: begin e.sa = 1; e.aop = 4'(in.aop); end
         S_MUL_WAIT: begin e.sa = 1; e.aop = 4'd9; end
         S_EXEC_I: begin e.sa = 1; e.sb = 2'd2; e.aop = 4'(in.aop); end
         S_WB_ALU: begin
            e.rw = 1; e.m2r = 2'd1;
            e.rd = (in.kind == K_ALU_R || in.kind == K_MUL) ? 2'd1 : 2'd0;
         end
         S_MEM_ADDR: begin e.sa = 1; e.sb = 2'd2; end
         S_MEM_RD: begin e.mr = 1; e.iord = 1; e.ldt = 2'(in.arg); end
         S_WB_MEM: e.rw = 1;
         S_MEM_WR: begin e.mw = 1; e.iord = 1; e.stt = 2'(in.arg); end
         S_BRANCH: begin
            e.sa = 1; e.aop = 4'd1; e.pcs = 2'd1;
            e.pcw = taken(in, a);
            e.ill = (in.kind == K_BRBAD);
         end
         S_JUMP: begin
            e.pcw = 1;
            e.pcs = (in.kind == K_JR) ? 2'd3 : 2'd2;
            if (in.kind == K_JAL) begin e.rw = 1; e.rd = 2'd2; e.m2r = 2'd2; end
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic clr();
      c_cycles = 0; c_mulwait = 0; c_rw = 0; c_mrd = 0; c_ill = 0;
      cap_jump = '1; cap_br = '1; cap_wbmem = '1; cap_wbalu = '1;
   endtask

   task automatic idle_cycle();
      @(negedge Clk);
      chk("idle", 32'(act), 32'(model(S_IDLE, tbl[0], 1'b1, 1)));
      @(posedge Clk); #1;
   endtask

   // rnd: random MemReady/ALU result; otherwise MemReady low for the first
   // 'stall' memory-phase cycles and a fixed ALU result.
   task automatic do_instr(int idx, bit rnd, int stall, int alu_fix, bit rst_mid);
      ins_t in;
      int   low_run, stalls;
      in = tbl[idx];
      low_run = 0; stalls = 0;
      OPCode = in.op; Function = in.fn; Rt = in.rt;
      build(in);
      foreach (seq[i]) begin
         state_t ph;
         bit     done;
         ph = seq[i];
         done = 1'b0;
         while (!done) begin
            bit rdy;
            int a;
            if (rnd) begin
               rdy = ($urandom_range(0, 3) != 0) || (low_run >= 3);
               a   = int'($urandom_range(0, 6)) - 3;
            end else begin
               rdy = !((ph == S_MEM_RD || ph == S_MEM_WR) && stalls < stall);
               a   = alu_fix;
            end
            low_run = rdy ? 0 : low_run + 1;
            if (!rdy) stalls++;
            MemReady = rdy; Zero = (a == 0); Neg = (a < 0);
            @(negedge Clk);
            chk({nm[idx], " cycle"}, 32'(act), 32'(model(ph, in, rdy, a)));
            c_cycles++;
            if (act.sid == 4'(S_MUL_WAIT) && ALUOp == 4'd9) c_mulwait++;
            if (RegWrite) c_rw++;
            if (MemRead && act.sid == 4'(S_MEM_RD)) c_mrd++;
            if (IllegalOp) c_ill++;
            if (act.sid == 4'(S_JUMP))   cap_jump  = act;
            if (act.sid == 4'(S_BRANCH)) cap_br    = act;
            if (act.sid == 4'(S_WB_MEM)) cap_wbmem = act;
            if (act.sid == 4'(S_WB_ALU)) cap_wbalu = act;
            if (rst_mid && ph == S_MEM_WR && stalls >= 2) begin
               #2 Rst = 1'b1;
               #1;
               chk("rst_mid_memwrite", 32'(MemWrite), 32'd0);
               chk("rst_mid_state", 32'(State), 32'(S_IDLE));
               chk("rst_mid_all", 32'(act), 32'd0);
               @(posedge Clk); #1 Rst = 1'b0;
               idle_cycle();
               return;
            end
            done = !((ph == S_FETCH || ph == S_MEM_RD || ph == S_MEM_WR) && !rdy);
            @(posedge Clk); #1;
         end
      end
   endtask

   initial begin
      add(6'b000000, 6'b100000, 5'd0, K_ALU_R, 0, 0, "add");
      add(6'b000000, 6'b100010, 5'd0, K_ALU_R, 1, 0, "sub");
      add(6'b000000, 6'b100100, 5'd0, K_ALU_R, 2, 0, "and");
      add(6'b000000, 6'b100101, 5'd0, K_ALU_R, 3, 0, "or");
      add(6'b000000, 6'b100110, 5'd0, K_ALU_R, 4, 0, "xor");
      add(6'b000000, 6'b100111, 5'd0, K_ALU_R, 5, 0, "nor");
      add(6'b000000, 6'b101010, 5'd0, K_ALU_R, 6, 0, "slt");
      add(6'b000000, 6'b000000, 5'd0, K_ALU_R, 7, 0, "sll");
      add(6'b000000, 6'b000010, 5'd0, K_ALU_R, 8, 0, "srl");
      add(6'b000000, 6'b011100, 5'd0, K_MUL,   9, 0, "mul");
      add(6'b000000, 6'b001000, 5'd0, K_JR,    0, 0, "jr");
      add(6'b001000, 6'b010101, 5'd3, K_ALU_I, 0, 0, "addi");
      add(6'b001100, 6'b000000, 5'd3, K_ALU_I, 2, 0, "andi");
      add(6'b001101, 6'b000000, 5'd3, K_ALU_I, 3, 0, "ori");
      add(6'b001110, 6'b000000, 5'd3, K_ALU_I, 4, 0, "xori");
      add(6'b001010, 6'b000000, 5'd3, K_ALU_I, 6, 0, "slti");
      add(6'b100011, 6'b000100, 5'd2, K_LOAD,  0, 0, "lw");
      add(6'b100001, 6'b000000, 5'd2, K_LOAD,  0, 1, "lh");
      add(6'b100000, 6'b000000, 5'd2, K_LOAD,  0, 2, "lb");
      add(6'b101011, 6'b000000, 5'd2, K_STORE, 0, 0, "sw");
      add(6'b101001, 6'b000000, 5'd2, K_STORE, 0, 1, "sh");
      add(6'b101000, 6'b000000, 5'd2, K_STORE, 0, 2, "sb");
      add(6'b000100, 6'b000000, 5'd4, K_BR,    0, 0, "beq");
      add(6'b000101, 6'b000000, 5'd4, K_BR,    0, 1, "bne");
      add(6'b000110, 6'b000000, 5'd0, K_BR,    0, 2, "blez");
      add(6'b000111, 6'b000000, 5'd0, K_BR,    0, 3, "bgtz");
      add(6'b000001, 6'b000000, 5'd1, K_BR,    0, 4, "bgez");
      add(6'b000001, 6'b000000, 5'd0, K_BR,    0, 5, "bltz");
      add(6'b000001, 6'b000000, 5'd5, K_BRBAD, 0, 0, "regimm_bad");
      add(6'b000010, 6'b000000, 5'd0, K_J,     0, 0, "j");
      add(6'b000011, 6'b000000, 5'd0, K_JAL,   0, 0, "jal");
      add(6'b111111, 6'b000000, 5'd0, K_ILL,   0, 0, "ill");
      add(6'b010000, 6'b000000, 5'd0, K_ILL,   0, 0, "cop0");

      // Model cycle counts with memory always ready.
      build(tbl[find("add")]); chk("model_len_alu",   32'(seq.size()), 32'd4);
      build(tbl[find("mul")]); chk("model_len_mul",   32'(seq.size()), 32'(4 + MUL_LAT));
      build(tbl[find("lw")]);  chk("model_len_load",  32'(seq.size()), 32'd5);
      build(tbl[find("sw")]);  chk("model_len_store", 32'(seq.size()), 32'd4);
      build(tbl[find("beq")]); chk("model_len_br",    32'(seq.size()), 32'd3);
      build(tbl[find("jal")]); chk("model_len_jump",  32'(seq.size()), 32'd3);

      @(negedge Clk);
      chk("reset_outputs", 32'(act), 32'd0);
      @(posedge Clk); #1 Rst = 1'b0;
      idle_cycle();

      clr(); do_instr(find("add"), 1'b0, 0, 1, 1'b0);
      chk("add_cycles", 32'(c_cycles), 32'd4);
      chk("add_wb_regwrite", 32'(cap_wbalu.rw), 32'd1);
      chk("add_wb_regdst", 32'(cap_wbalu.rd), 32'd1);

      clr(); do_instr(find("mul"), 1'b0, 0, 1, 1'b0);
      chk("mul_wait_cycles", 32'(c_mulwait), 32'(MUL_LAT));
      chk("mul_regwrite_pulses", 32'(c_rw), 32'd1);

      clr(); do_instr(find("lw"), 1'b0, 2, 1, 1'b0);
      chk("lw_memread_cycles", 32'(c_mrd), 32'd3);
      chk("lw_wbmem", 32'({cap_wbmem.rw, cap_wbmem.m2r, cap_wbmem.ldt}), 32'({1'b1, 2'd0, 2'd0}));

      clr(); do_instr(find("bltz"), 1'b0, 0, -1, 1'b0);
      chk("bltz_neg", 32'({cap_br.pcw, cap_br.pcs}), 32'({1'b1, 2'd1}));
      clr(); do_instr(find("bgez"), 1'b0, 0, -1, 1'b0);
      chk("bgez_neg", 32'(cap_br.pcw), 32'd0);

      clr(); do_instr(find("jal"), 1'b0, 0, 1, 1'b0);
      chk("jal_jump", 32'({cap_jump.pcw, cap_jump.pcs, cap_jump.rw, cap_jump.rd, cap_jump.m2r}),
          32'({1'b1, 2'd2, 1'b1, 2'd2, 2'd2}));

      clr(); do_instr(find("ill"), 1'b0, 0, 1, 1'b0);
      chk("ill_pulses", 32'(c_ill), 32'd1);
      chk("ill_to_fetch", 32'(State), 32'(S_FETCH));

      clr(); do_instr(find("sw"), 1'b0, 3, 1, 1'b1);

      clr(); do_instr(find("mul"), 1'b0, 0, 1, 1'b0);
      chk("mul_after_reset", 32'(c_mulwait), 32'(MUL_LAT));

      for (int n = 0; n < 300; n++)
         do_instr(int'($urandom_range(0, tbl.size() - 1)), 1'b1, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
